pc_sequencer: RTL

- Parametrised next-generation program-counter unit for the fetch stage. Replaces the fixed 64-bit PC+4 incrementer.
- Holds the PC register and presents it to instruction fetch over a valid/ready handshake.
- Applies stall, taken-branch and return redirects, and keeps a small circular return-address stack (RAS) for BL/RET.

---
 rtl/pc_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter unit: holds the PC, sequences it over a valid/ready
// handshake, applies branch/return redirects and keeps a circular return-address stack.
module pc_sequencer #(
  parameter int                ADDR_W    = 64,
  parameter int                INC       = 4,
  parameter int                OFF_W     = 26,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int                RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              fetch_ready,
  input  logic              branch_taken,
  input  logic              branch_link,
  input  logic [ADDR_W-1:0] branch_base,
  input  logic [OFF_W-1:0]  branch_off,
  input  logic              ret,
  input  logic [ADDR_W-1:0] ret_reg,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  output logic [ADDR_W-1:0] pc_next_seq,
  output logic              ret_miss,
  output logic              ras_empty,
  output logic              ras_ovf
);

  localparam int                PTR_W = $clog2(RAS_DEPTH);
  localparam int                CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] INC_A = ADDR_W'(INC);
  localparam logic [CNT_W-1:0]  FULL  = CNT_W'(RAS_DEPTH);

  typedef enum logic [1:0] {BOOT, RUN, BUBBLE} state_t;

  // Word offset is sign-extended to the full address width before scaling to bytes.
  function automatic logic [ADDR_W-1:0] branch_target(input logic [ADDR_W-1:0] base,
                                                     input logic [OFF_W-1:0]  off);
    logic signed [ADDR_W-1:0] off_ext;
    off_ext = {{(ADDR_W-OFF_W){off[OFF_W-1]}}, off};
    return base + $unsigned(off_ext <<< 2);
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pc_valid_q, pc_valid_d;
  logic              ret_miss_q, ret_miss_d;
  logic              ras_ovf_q, ras_ovf_d;
  logic [PTR_W-1:0]  sp_q, sp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

  logic              redirect, push, pop, empty, full;
  logic [PTR_W-1:0]  top_idx;

  assign top_idx = sp_q - PTR_W'(1);
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL);

  always_comb begin
    redirect   = branch_taken | ret;
    push       = branch_taken & branch_link;
    pop        = ret & ~branch_taken & ~empty;
    pc_d       = pc_q;
    sp_d       = sp_q;
    cnt_d      = cnt_q;
    ras_ovf_d  = ras_ovf_q;
    ret_miss_d = ret & ~branch_taken & empty;

    if (branch_taken) begin
      pc_d = branch_target(branch_base, branch_off);
    end else if (ret) begin
      pc_d = empty ? ret_reg : ras_q[top_idx];
    end else if (state_q == RUN && fetch_ready && !stall) begin
      pc_d = pc_q + INC_A;
    end

    // When full, sp already points at the oldest entry, so the push overwrites it.
    if (push) begin
      sp_d = sp_q + PTR_W'(1);
      if (full) ras_ovf_d = 1'b1;
      else      cnt_d     = cnt_q + CNT_W'(1);
    end else if (pop) begin
      sp_d  = top_idx;
      cnt_d = cnt_q - CNT_W'(1);
    end

    state_d    = redirect ? BUBBLE : RUN;
    pc_valid_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VEC;
      pc_valid_q <= 1'b0;
      ret_miss_q <= 1'b0;
      ras_ovf_q  <= 1'b0;
      sp_q       <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      ret_miss_q <= ret_miss_d;
      ras_ovf_q  <= ras_ovf_d;
      sp_q       <= sp_d;
      cnt_q      <= cnt_d;
    end
  end

  // Stack storage needs no reset: an empty count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) ras_q[sp_q] <= branch_base + INC_A;
  end

  assign pc          = pc_q;
  assign pc_valid    = pc_valid_q;
  assign pc_next_seq = pc_q + INC_A;
  assign ret_miss    = ret_miss_q;
  assign ras_empty   = empty;
  assign ras_ovf     = ras_ovf_q;

endmodule
